diff_threshold_ctrl: RTL and testbench
======================================

Name: diff_threshold_ctrl

Overview:
Frame-level controller for the frame-difference binarization stage. It counts motion pixels per frame from the binarizer output and adapts the binarization threshold between frames. It also masks warm-up frames and raises a debounced motion alarm. Sits after the binarizer; thr_out feeds back into the binarizer's threshold input and is only updated at frame boundaries.

Parameters:
THR_RESET, 8'd30, thr_out value after reset
THR_MIN, 8'd8, lower saturation bound of adaptive threshold
THR_MAX, 8'd120, upper saturation bound of adaptive threshold
THR_STEP, 8'd2, per-frame threshold adjustment step
CNT_W, 20, width of per-frame motion pixel counter
CNT_HI, 20'd40000, frame count above which threshold increases
CNT_LO, 20'd2000, frame count below which threshold decreases
MOTION_PIX, 20'd5000, per-frame count at or above which a frame is a "motion frame"
ALARM_FRAMES, 3, consecutive frames needed to set or clear motion_flag (1..7)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
bin_clken  in  1  binarizer pixel-valid strobe
bin_href  in  1  binarizer line-valid
bin_vsync  in  1  binarizer frame sync, high during vertical blanking
bin_bit  in  1  binarized pixel, 1 = motion
cfg_auto_en  in  1  1 = adaptive threshold, 0 = fixed threshold from cfg_thr
cfg_thr  in  8  fixed threshold, used when cfg_auto_en=0
thr_out  out  8  threshold driven to binarizer
frame_valid  out  1  1 once warm-up is complete; binarizer output is meaningful
frame_done  out  1  one-cycle pulse when frame statistics are updated
motion_cnt  out  CNT_W  motion pixel count of last completed frame
motion_flag  out  1  debounced motion alarm

Behaviour:
- Reset values: thr_out=THR_RESET, frame_valid=0, frame_done=0, motion_cnt=0, motion_flag=0. FSM=SYNC. Accumulator=0, debounce counters=0, vsync_q=0.
- Frame boundary (edge) = bin_vsync=1 and vsync_q=0 in the same cycle. vsync_q is bin_vsync registered.
- Accumulator increments when bin_clken & bin_href & bin_bit. It saturates at all-ones and does not wrap.
- FSM:
  - SYNC: wait for the first edge, discard the accumulator, go to WARMUP.
  - WARMUP: the first full frame has no valid previous frame. At the next edge, discard the accumulator, set frame_valid=1 and go to RUN.
  - RUN: stays in RUN. Each edge triggers the update pipeline.
- Update pipeline, RUN only:
  - Edge cycle (cycle E): a pixel qualified in cycle E is counted into the ending frame. The accumulator value including that pixel is latched into an internal snapshot, and the accumulator clears to 0.
  - Cycle E+1: motion_cnt<=snapshot, thr_out updated, debounce updated, motion_flag updated, frame_done=1 for exactly this cycle.
- Threshold rule at E+1:
  - cfg_auto_en=0: thr_out<=cfg_thr, no clamping.
  - cfg_auto_en=1: if snapshot>CNT_HI, thr_out<=min(thr_out+THR_STEP, THR_MAX). If snapshot<CNT_LO, thr_out<=max(thr_out-THR_STEP, THR_MIN). Otherwise hold.
  - Arithmetic is 9-bit to avoid overflow or underflow before clamping.
  - If thr_out lies outside [THR_MIN, THR_MAX] when auto is enabled, it clamps to the bound on the first update.
- thr_out never changes mid-frame. cfg_* changes mid-frame take effect at the next E+1.
- Debounce:
  - A frame is a motion frame when snapshot>=MOTION_PIX.
  - on_cnt counts consecutive motion frames and clears on a non-motion frame. off_cnt counts the converse. Both saturate at ALARM_FRAMES.
  - motion_flag sets when on_cnt reaches ALARM_FRAMES and clears when off_cnt reaches ALARM_FRAMES.
- Edges in SYNC/WARMUP produce no frame_done and no thr_out change.
- Async reset mid-frame returns to SYNC; the next partial frame is never counted.
- A second edge arriving at E+1 is impossible (vsync_q guards it). Back-to-back edges need vsync low for at least 1 cycle.

Optional Feature:
Macro DIFF_CTRL_PEAK_EN.
- Defined: adds output peak_cnt (CNT_W), reset 0, updated at E+1 to max(peak_cnt, snapshot). Adds input peak_clr (1), which clears peak_cnt to 0 synchronously. If peak_clr coincides with E+1, the clear wins and peak_cnt becomes 0 (the new snapshot is not taken).
- Not defined: neither port exists and no peak logic is synthesized.

Test Plan:
- Reset, then 3 frames of 100 motion pixels each, auto=1 -> no frame_done in frames 0-1. frame_valid=1 after the 2nd edge. At 3rd edge+1: frame_done=1, motion_cnt=100, thr_out=28 (100<CNT_LO).
- 60000 motion pixels per frame, auto=1 -> thr_out goes 30,32,34... and saturates at 120. It never changes while bin_vsync is low.
- 6000 pixels/frame for 3 RUN frames -> motion_flag=1 at 3rd frame_done. Then 1000/frame -> clears at 3rd subsequent frame_done. An alternating pattern never toggles the flag.
- Qualified pixel asserted in the edge cycle, frame otherwise 9 pixels -> motion_cnt=10; the next frame starts from 0.
- cfg_auto_en=0, cfg_thr=200 written mid-frame -> thr_out=200 only at the following E+1, no clamping to THR_MAX.
- rst_n pulsed low mid-frame in RUN -> all outputs return to reset values immediately. The FSM re-syncs, and the next frame_done occurs only after SYNC plus the WARMUP frame.

Source files
------------

// File: rtl/diff_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// diff_threshold_ctrl
//
// Frame-level controller for the frame-difference binarization stage.
// Counts motion pixels per frame from the binarizer output, adapts the
// binarization threshold between frames, masks the warm-up frames after
// reset and raises a debounced motion alarm. thr_out feeds back into the
// binarizer threshold input and only ever changes at a frame boundary.
//
// Optional feature macro: DIFF_CTRL_PEAK_EN
//   When defined, adds input peak_clr and output peak_cnt, which tracks the
//   largest per-frame motion count seen since reset or the last clear.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   bin_clken    binarizer pixel-valid strobe
//   bin_href     binarizer line-valid
//   bin_vsync    binarizer frame sync, high during vertical blanking
//   bin_bit      binarized pixel, 1 = motion
//   cfg_auto_en  1 = adaptive threshold, 0 = fixed threshold from cfg_thr
//   cfg_thr      fixed threshold used when cfg_auto_en = 0
//   peak_clr     (DIFF_CTRL_PEAK_EN only) synchronous clear of peak_cnt
//   peak_cnt     (DIFF_CTRL_PEAK_EN only) largest completed-frame count
//   thr_out      threshold driven to the binarizer
//   frame_valid  1 once warm-up is complete
//   frame_done   one-cycle pulse when frame statistics are updated
//   motion_cnt   motion pixel count of the last completed frame
//   motion_flag  debounced motion alarm
// ---------------------------------------------------------------------------
module diff_threshold_ctrl #(
  parameter logic [7:0] THR_RESET    = 8'd30,
  parameter logic [7:0] THR_MIN      = 8'd8,
  parameter logic [7:0] THR_MAX      = 8'd120,
  parameter logic [7:0] THR_STEP     = 8'd2,
  parameter int         CNT_W        = 20,
  parameter int         CNT_HI       = 40000,
  parameter int         CNT_LO       = 2000,
  parameter int         MOTION_PIX   = 5000,
  parameter int         ALARM_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bin_clken,
  input  logic             bin_href,
  input  logic             bin_vsync,
  input  logic             bin_bit,
  input  logic             cfg_auto_en,
  input  logic [7:0]       cfg_thr,
`ifdef DIFF_CTRL_PEAK_EN
  input  logic             peak_clr,
  output logic [CNT_W-1:0] peak_cnt,
`endif
  output logic [7:0]       thr_out,
  output logic             frame_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] motion_cnt,
  output logic             motion_flag
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CntHi     = CNT_W'(CNT_HI);
  localparam logic [CNT_W-1:0] CntLo     = CNT_W'(CNT_LO);
  localparam logic [CNT_W-1:0] MotionPix = CNT_W'(MOTION_PIX);
  localparam logic [2:0]       AlarmN    = 3'(ALARM_FRAMES);

  state_t           state_q;
  logic             vsync_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic [7:0]       thr_q;
  logic [7:0]       thr_d;
  logic             valid_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_q;
  logic             flag_d;
  logic [2:0]       on_q;
  logic [2:0]       on_d;
  logic [2:0]       off_q;
  logic [2:0]       off_d;

  logic             qual_pix;
  logic             frame_edge;
  logic             is_motion;
  logic [8:0]       thr_up;
  logic [8:0]       thr_dn;
  logic [8:0]       thr_auto;

  assign qual_pix   = bin_clken & bin_href & bin_bit;
  assign frame_edge = bin_vsync & ~vsync_q;

  // Accumulator next value including the pixel of the current cycle. At an
  // edge this is also the snapshot of the ending frame, so a pixel that
  // coincides with the edge still belongs to the frame that is closing.
  always_comb begin
    acc_d = acc_q;
    if (qual_pix && (acc_q != {CNT_W{1'b1}})) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  // Threshold adaptation in 9 bits so the step can never wrap before the
  // clamp. The final clamp also pulls a fixed threshold that was outside the
  // adaptive range back into it on the first auto update.
  always_comb begin
    thr_up = {1'b0, thr_q} + {1'b0, THR_STEP};
    thr_dn = (thr_q >= THR_STEP) ? ({1'b0, thr_q} - {1'b0, THR_STEP}) : 9'd0;
    if (acc_d > CntHi) begin
      thr_auto = thr_up;
    end else if (acc_d < CntLo) begin
      thr_auto = thr_dn;
    end else begin
      thr_auto = {1'b0, thr_q};
    end
    if (!cfg_auto_en) begin
      thr_d = cfg_thr;
    end else if (thr_auto > {1'b0, THR_MAX}) begin
      thr_d = THR_MAX;
    end else if (thr_auto < {1'b0, THR_MIN}) begin
      thr_d = THR_MIN;
    end else begin
      thr_d = thr_auto[7:0];
    end
  end

  // Debounce: consecutive motion / quiet frame counters, each saturating at
  // the alarm length. The flag only moves when one of them reaches it, so an
  // alternating pattern leaves the flag where it was.
  always_comb begin
    is_motion = (acc_d >= MotionPix);
    on_d      = on_q;
    off_d     = off_q;
    flag_d    = flag_q;
    if (is_motion) begin
      off_d = 3'd0;
      on_d  = (on_q < AlarmN) ? on_q + 3'd1 : AlarmN;
      if (on_d == AlarmN) begin
        flag_d = 1'b1;
      end
    end else begin
      on_d  = 3'd0;
      off_d = (off_q < AlarmN) ? off_q + 3'd1 : AlarmN;
      if (off_d == AlarmN) begin
        flag_d = 1'b0;
      end
    end
  end

  // Frame sequencer. SYNC and WARMUP throw away whatever was accumulated,
  // because the binarizer has no valid previous frame yet. In RUN every edge
  // commits the frame statistics so they are visible during cycle E+1, with
  // frame_done marking that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      vsync_q <= 1'b0;
      acc_q   <= '0;
      thr_q   <= THR_RESET;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      on_q    <= 3'd0;
      off_q   <= 3'd0;
    end else begin
      vsync_q <= bin_vsync;
      done_q  <= 1'b0;
      case (state_q)
        SYNC: begin
          if (frame_edge) begin
            acc_q   <= '0;
            state_q <= WARMUP;
          end else begin
            acc_q <= acc_d;
          end
        end
        WARMUP: begin
          if (frame_edge) begin
            acc_q   <= '0;
            valid_q <= 1'b1;
            state_q <= RUN;
          end else begin
            acc_q <= acc_d;
          end
        end
        RUN: begin
          if (frame_edge) begin
            acc_q  <= '0;
            cnt_q  <= acc_d;
            thr_q  <= thr_d;
            on_q   <= on_d;
            off_q  <= off_d;
            flag_q <= flag_d;
            done_q <= 1'b1;
          end else begin
            acc_q <= acc_d;
          end
        end
        default: begin
          acc_q   <= '0;
          state_q <= SYNC;
        end
      endcase
    end
  end

`ifdef DIFF_CTRL_PEAK_EN
  logic [CNT_W-1:0] peak_q;

  // During E+1 motion_cnt already holds the snapshot, so the peak compares
  // against it. A clear in that same cycle wins over the new snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= '0;
    end else if (done_q && (cnt_q > peak_q)) begin
      peak_q <= cnt_q;
    end
  end

  assign peak_cnt = peak_q;
`endif

  assign thr_out     = thr_q;
  assign frame_valid = valid_q;
  assign frame_done  = done_q;
  assign motion_cnt  = cnt_q;
  assign motion_flag = flag_q;

endmodule

// File: tb/tb_diff_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_diff_threshold_ctrl
//
// Self-checking bench for diff_threshold_ctrl (default build, peak feature
// off). Drives frames of binarizer traffic and compares the controller
// outputs against a frame-level reference model of the threshold, debounce
// and warm-up rules. Inputs change and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_diff_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bin_clken;
  logic        bin_href;
  logic        bin_vsync;
  logic        bin_bit;
  logic        cfg_auto_en;
  logic [7:0]  cfg_thr;
  logic [7:0]  thr_out;
  logic        frame_valid;
  logic        frame_done;
  logic [19:0] motion_cnt;
  logic        motion_flag;

  int compared   = 0;
  int mismatched = 0;
  int frameNo    = 0;

  // Reference model state: edges seen since reset, current frame pixel count
  // and the expected visible outputs.
  int edgesM;
  int pixM;
  int thrM;
  int cntM;
  int validM;
  int flagM;
  int onM;
  int offM;

  diff_threshold_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bin_clken   (bin_clken),
    .bin_href    (bin_href),
    .bin_vsync   (bin_vsync),
    .bin_bit     (bin_bit),
    .cfg_auto_en (cfg_auto_en),
    .cfg_thr     (cfg_thr),
    .thr_out     (thr_out),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .motion_cnt  (motion_cnt),
    .motion_flag (motion_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s frame=%0d observed=%0d expected=%0d", tag, frameNo, obs, exp);
    end
  endtask

  task automatic resetModel();
    edgesM = 0;
    pixM   = 0;
    thrM   = 30;
    cntM   = 0;
    validM = 0;
    flagM  = 0;
    onM    = 0;
    offM   = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_thr"},   thr_out,     thrM);
    checkOutput({tag, "_valid"}, frame_valid, validM);
    checkOutput({tag, "_cnt"},   motion_cnt,  cntM);
    checkOutput({tag, "_flag"},  motion_flag, flagM);
  endtask

  // One qualified pixel, optionally preceded by a random non-qualifying cycle.
  task automatic drivePix(input bit noisy);
    logic [2:0] r;
    if (noisy && ($urandom_range(0, 7) == 0)) begin
      r = 3'($urandom_range(0, 6));
      {bin_clken, bin_href, bin_bit} = r;
      @(negedge clk);
    end
    {bin_clken, bin_href, bin_bit} = 3'b111;
    pixM++;
    @(negedge clk);
    {bin_clken, bin_href, bin_bit} = 3'b000;
  endtask

  // Rest of a frame: nPix more motion pixels, then the vsync edge with an
  // optional pixel in the edge cycle, then the E+1 and E+2 checks.
  task automatic applyStimulus(input int nPix, input bit edgePix, input bit noisy);
    int t;
    int doneExp;
    for (int i = 0; i < nPix; i++) begin
      if (i == nPix / 2) begin
        checkOutput("mid_thr", thr_out, thrM);
        checkOutput("mid_done", frame_done, 0);
      end
      drivePix(noisy);
    end
    bin_vsync = 1'b1;
    {bin_clken, bin_href, bin_bit} = edgePix ? 3'b111 : 3'b000;
    pixM += int'(edgePix);
    @(negedge clk);
    {bin_clken, bin_href, bin_bit} = 3'b000;

    doneExp = 0;
    edgesM++;
    if (edgesM >= 3) begin
      doneExp = 1;
      cntM = pixM;
      if (!cfg_auto_en) begin
        thrM = int'(cfg_thr);
      end else begin
        t = thrM;
        if (pixM > 40000) t = t + 2;
        else if (pixM < 2000) t = t - 2;
        if (t > 120) t = 120;
        if (t < 8) t = 8;
        thrM = t;
      end
      if (pixM >= 5000) begin
        offM = 0;
        onM  = (onM < 3) ? onM + 1 : 3;
        if (onM == 3) flagM = 1;
      end else begin
        onM  = 0;
        offM = (offM < 3) ? offM + 1 : 3;
        if (offM == 3) flagM = 0;
      end
    end else if (edgesM == 2) begin
      validM = 1;
    end
    pixM = 0;

    checkOutput("edge_done", frame_done, doneExp);
    checkAll("edge");
    @(negedge clk);
    checkOutput("done_pulse", frame_done, 0);
    @(negedge clk);
    bin_vsync = 1'b0;
    @(negedge clk);
    frameNo++;
  endtask

  initial begin
    rst_n       = 1'b0;
    bin_clken   = 1'b0;
    bin_href    = 1'b0;
    bin_vsync   = 1'b0;
    bin_bit     = 1'b0;
    cfg_auto_en = 1'b1;
    cfg_thr     = 8'd0;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_done", frame_done, 0);
    checkAll("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Pre-sync frame, warm-up frame, first RUN frame: 100 px -> thr 28.
    applyStimulus(100, 1'b0, 1'b1);
    applyStimulus(100, 1'b0, 1'b1);
    applyStimulus(100, 1'b0, 1'b1);

    // Pixel in the edge cycle belongs to the closing frame; next starts at 0.
    applyStimulus(9, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);

    // Fixed threshold written mid-frame only lands at the next E+1, unclamped.
    for (int i = 0; i < 50; i++) drivePix(1'b0);
    cfg_auto_en = 1'b0;
    cfg_thr     = 8'd200;
    @(negedge clk);
    checkOutput("cfg_midframe_thr", thr_out, thrM);
    applyStimulus(50, 1'b0, 1'b0);

    // Auto with count exactly CNT_LO holds, but 200 clamps to THR_MAX.
    cfg_auto_en = 1'b1;
    applyStimulus(2000, 1'b0, 1'b0);

    // 119 + step saturates at 120 on a frame above CNT_HI.
    cfg_auto_en = 1'b0;
    cfg_thr     = 8'd119;
    applyStimulus(10, 1'b0, 1'b0);
    cfg_auto_en = 1'b1;
    applyStimulus(40001, 1'b0, 1'b0);

    // 5 - step clamps up to THR_MIN.
    cfg_auto_en = 1'b0;
    cfg_thr     = 8'd5;
    applyStimulus(10, 1'b0, 1'b0);
    cfg_auto_en = 1'b1;
    applyStimulus(100, 1'b0, 1'b0);

    // Debounce: three motion frames set the flag, alternation holds it,
    // three quiet frames clear it.
    repeat (3) applyStimulus(5000, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(5000, 1'b0, 1'b0);
    repeat (3) applyStimulus(1000, 1'b0, 1'b0);

    // Randomized frames and configuration.
    repeat (5) begin
      cfg_auto_en = ($urandom_range(0, 3) != 0);
      cfg_thr     = 8'($urandom_range(0, 255));
      applyStimulus(int'($urandom_range(0, 5200)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset mid-frame, then a full re-sync.
    cfg_auto_en = 1'b1;
    for (int i = 0; i < 300; i++) drivePix(1'b1);
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midrst_done", frame_done, 0);
    checkAll("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(200, 1'b0, 1'b1);
    applyStimulus(30, 1'b0, 1'b1);
    applyStimulus(50, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
